// File: rtl/reseed_lfsr_prng_if.sv
// Control, entropy and data signals of the reseedable LFSR PRNG.
// The slave modport is the generator's view; the master modport is the driver's view.
interface reseed_lfsr_prng_if #(
    parameter int EntropyWidth = 32,
    parameter int LfsrWidth    = 64
);
    logic                    lfsr_en_i;
    logic                    reseed_req_i;
    logic                    reseed_ack_o;
    logic                    entropy_req_o;
    logic                    entropy_ack_i;
    logic [EntropyWidth-1:0] entropy_i;
    logic [LfsrWidth-1:0]    state_o;
    logic [LfsrWidth-1:0]    data_o;

    modport slave (
        input  lfsr_en_i,
        input  reseed_req_i,
        input  entropy_ack_i,
        input  entropy_i,
        output reseed_ack_o,
        output entropy_req_o,
        output state_o,
        output data_o
    );

    modport master (
        output lfsr_en_i,
        output reseed_req_i,
        output entropy_ack_i,
        output entropy_i,
        input  reseed_ack_o,
        input  entropy_req_o,
        input  state_o,
        input  data_o
    );
endinterface

// File: rtl/reseed_lfsr_prng.sv
// 64-bit Galois LFSR reseeded from two 32-bit entropy words, with a
// PRINCE S-box scrambled copy of the state for register clearing.
module reseed_lfsr_prng #(
    parameter int              EntropyWidth = 32,
    parameter int              LfsrWidth    = 64,
    parameter logic [LfsrWidth-1:0] DefaultSeed = 64'h0123_4567_89AB_CDEF,
    parameter logic [LfsrWidth-1:0] Coeffs      = 64'hD800_0000_0000_0000,
    parameter bit              SkipReseed   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    reseed_lfsr_prng_if.slave    bus
);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hB;
            4'h1: y = 4'hF;
            4'h2: y = 4'h3;
            4'h3: y = 4'h2;
            4'h4: y = 4'hA;
            4'h5: y = 4'hC;
            4'h6: y = 4'h9;
            4'h7: y = 4'h1;
            4'h8: y = 4'h6;
            4'h9: y = 4'h7;
            4'hA: y = 4'h8;
            4'hB: y = 4'h0;
            4'hC: y = 4'hE;
            4'hD: y = 4'h5;
            4'hE: y = 4'hD;
            default: y = 4'h4;
        endcase
        return y;
    endfunction

    logic [1:0]           r_depth;
    logic [LfsrWidth-1:0] r_pack;
    logic [LfsrWidth-1:0] r_state;
    logic                 w_seed_valid;
    logic                 w_seed_en;
    logic [LfsrWidth-1:0] w_step;
    logic [LfsrWidth-1:0] w_scr;

    assign w_seed_valid = (r_depth == 2'd2);
    assign w_seed_en    = SkipReseed ? 1'b0 : w_seed_valid;

    // Packer: the full seed is always drained on the edge after it completes,
    // so words offered while full are simply not taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_depth <= 2'd0;
            r_pack  <= '0;
        end else if (w_seed_valid) begin
            r_depth <= 2'd0;
            r_pack  <= '0;
        end else if (bus.entropy_ack_i) begin
            if (r_depth == 2'd0) begin
                r_pack[EntropyWidth-1:0] <= bus.entropy_i;
            end else begin
                r_pack[LfsrWidth-1:EntropyWidth] <= bus.entropy_i;
            end
            r_depth <= r_depth + 2'd1;
        end
    end

    assign w_step = (r_state >> 1) ^ (r_state[0] ? Coeffs : '0);

    // An all-zero state would lock the LFSR, so stepping from zero restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= DefaultSeed;
        end else if (w_seed_en) begin
            r_state <= r_pack;
        end else if (bus.lfsr_en_i) begin
            r_state <= (r_state == '0) ? DefaultSeed : w_step;
        end
    end

    always_comb begin
        w_scr = '0;
        for (int n = 0; n < LfsrWidth / 4; n++) begin
            w_scr[4*n +: 4] = sbox(r_state[4*n +: 4]);
        end
    end

    assign bus.state_o       = r_state;
    assign bus.data_o        = w_scr;
    assign bus.reseed_ack_o  = SkipReseed ? bus.reseed_req_i : w_seed_valid;
    assign bus.entropy_req_o = SkipReseed ? 1'b0 : (bus.reseed_req_i & ~w_seed_valid);

endmodule

// File: tb/tb_reseed_lfsr_prng.sv
// Bench for reseed_lfsr_prng: a normal and a SkipReseed instance driven in
// lockstep and compared every cycle against a word-list reference model.
module tb_reseed_lfsr_prng;

    localparam logic [63:0] DEF  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] COEF = 64'hD800_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reseed_lfsr_prng_if #(.EntropyWidth(32), .LfsrWidth(64)) bus0 ();
    reseed_lfsr_prng_if #(.EntropyWidth(32), .LfsrWidth(64)) bus1 ();

    reseed_lfsr_prng #(.SkipReseed(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    reseed_lfsr_prng #(.SkipReseed(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, the LFSR value and the list of accepted entropy words.
    logic [63:0] m_state [2];
    logic [31:0] m_words [2][$];
    logic [3:0]  SB [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                             4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    function automatic logic [63:0] scramble(input logic [63:0] s);
        logic [63:0] r = '0;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = SB[s[4*n +: 4]];
        return r;
    endfunction

    task automatic cyc(input bit do_chk, input logic r, input logic en, input logic req,
                       input logic ack, input logic [31:0] w);
        logic [63:0] got_state [2];
        logic [63:0] got_data  [2];
        logic        got_ack   [2];
        logic        got_req   [2];
        rst = r;
        bus0.lfsr_en_i = en;  bus0.reseed_req_i = req;  bus0.entropy_ack_i = ack;  bus0.entropy_i = w;
        bus1.lfsr_en_i = en;  bus1.reseed_req_i = req;  bus1.entropy_ack_i = ack;  bus1.entropy_i = w;
        @(negedge clk);
        got_state[0] = bus0.state_o; got_data[0] = bus0.data_o;
        got_ack[0]   = bus0.reseed_ack_o; got_req[0] = bus0.entropy_req_o;
        got_state[1] = bus1.state_o; got_data[1] = bus1.data_o;
        got_ack[1]   = bus1.reseed_ack_o; got_req[1] = bus1.entropy_req_o;
        for (int k = 0; k < 2; k++) begin
            bit skip = (k == 1);
            bit full = (m_words[k].size() == 2);
            if (do_chk) begin
                chk_eq($sformatf("state[%0d]", k), got_state[k], m_state[k]);
                chk_eq($sformatf("data[%0d]", k), got_data[k], scramble(m_state[k]));
                chk_eq($sformatf("reseed_ack[%0d]", k), 64'(got_ack[k]), 64'(skip ? req : full));
                chk_eq($sformatf("entropy_req[%0d]", k), 64'(got_req[k]), 64'(skip ? 1'b0 : (req & ~full)));
            end
            if (r) begin
                m_state[k] = DEF;
                m_words[k].delete();
            end else begin
                if (full && !skip)
                    m_state[k] = {m_words[k][1], m_words[k][0]};
                else if (en)
                    m_state[k] = (m_state[k] == 0) ? DEF
                               : ((m_state[k] >> 1) ^ (m_state[k][0] ? COEF : 64'h0));
                if (full) m_words[k].delete();
                else if (ack) m_words[k].push_back(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic req_r;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("rst_state", bus0.state_o, 64'h0123456789ABCDEF);
        chk_eq("rst_data", bus0.data_o, 64'hBF32AC916780E5D4);
        chk_eq("rst_ack", 64'(bus0.reseed_ack_o), 64'h0);
        chk_eq("rst_req", 64'(bus0.entropy_req_o), 64'h0);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_eq("step1", bus0.state_o, 64'hD891A2B3C4D5E6F7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("hold", bus0.state_o, 64'hD891A2B3C4D5E6F7);

        // Reseed with the default seed's two halves, then keep requesting.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h89ABCDEF);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h01234567);
        chk_eq("ack_cycle", 64'(bus0.reseed_ack_o), 64'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_eq("reseed_val", bus0.state_o, DEF);
        chk_eq("ack_gone", 64'(bus0.reseed_ack_o), 64'h0);
        chk_eq("req_back", 64'(bus0.entropy_req_o), 64'h1);
        chk_eq("skip_state", bus1.state_o, 64'hD891A2B3C4D5E6F7);

        // Zero seed, then lockup recovery.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("zero_seed", bus0.state_o, 64'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_eq("lockup", bus0.state_o, DEF);

        // Seed beats step; third word during full is dropped.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333);
        chk_eq("seed_not_step", bus0.state_o, 64'h2222222211111111);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55555555);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_eq("drop_third", bus0.state_o, 64'h5555555544444444);

        // Reset in the middle of packing discards the partial word.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000BBBB);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("rst_midpack", bus0.state_o, 64'h0000BBBBAAAA0000);

        req_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            if ($urandom_range(0, 9) == 0) req_r = ~req_r;
            w = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cyc(1'b1, ($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), req_r,
                1'($urandom_range(0, 1)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
